// File: rtl/urv_divide.sv
`default_nettype none
// ============================================================================
//  Module      : urv_divide
//  Description : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/
//                REMU. One quotient bit per clock, sign fix-up and RISC-V
//                divide-by-zero / signed-overflow results, one-cycle done.
//  Revision    : 1.0 - initial release
// ============================================================================
module urv_divide #(
    parameter int EARLY_OUT = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic [2:0]  d_fun_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] w_rd_o
);

    localparam logic c_early_out = (EARLY_OUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_dividend;    // shifted-out dividend magnitude
    logic [31:0] r_divisor;     // divisor magnitude
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_rs1;         // raw dividend, returned by REM on divide-by-zero
    logic [31:0] r_rd;
    logic [4:0]  r_count;
    logic        r_signed;
    logic        r_rem_sel;
    logic        r_q_sign;
    logic        r_r_sign;
    logic        r_div0;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;

    // Operand decode, only meaningful while idle
    logic        w_signed;
    logic        w_start;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_fun_unused;

    // funct3 bit 2 is constant for the M-extension divides; decode uses bits 1:0
    assign w_fun_unused = d_fun_i[2];

    assign w_signed  = ~d_fun_i[0];
    assign w_start   = start_i & ~kill_i;
    assign w_div0    = (d_rs2_i == 32'd0);
    assign w_ovf     = w_signed && (d_rs1_i == 32'h8000_0000) && (d_rs2_i == 32'hFFFF_FFFF);
    assign w_special = w_div0 | w_ovf;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_mag1    = (w_signed && d_rs1_i[31]) ? (32'd0 - d_rs1_i) : d_rs1_i;
    assign w_mag2    = (w_signed && d_rs2_i[31]) ? (32'd0 - d_rs2_i) : d_rs2_i;

    // One restoring step: the 33-bit difference's top bit is the borrow,
    // valid because the partial remainder is always below the divisor.
    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic        w_ge;

    assign w_trial = {r_rem, r_dividend[31]};
    assign w_diff  = w_trial - {1'b0, r_divisor};
    assign w_ge    = ~w_diff[32];

    // Final result selection with sign fix-up and architectural overrides
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_result;

    // Sign-correct the selected result, then apply special-case values
    always_comb begin
        w_q_fix  = (r_signed && r_q_sign) ? (32'd0 - r_quot) : r_quot;
        w_r_fix  = (r_signed && r_r_sign) ? (32'd0 - r_rem)  : r_rem;
        w_result = r_rem_sel ? w_r_fix : w_q_fix;
        if (r_div0) begin
            w_result = r_rem_sel ? r_rs1 : 32'hFFFF_FFFF;
        end else if (r_ovf) begin
            w_result = r_rem_sel ? 32'd0 : 32'h8000_0000;
        end
    end

    // Next-state logic: kill returns to idle from any active state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = (c_early_out && w_special) ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                if (kill_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count == 5'd31) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered busy/done flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (r_state == ST_FIX) && !kill_i;
        end
    end

    // Operand capture on accepted start, then one quotient bit per CALC edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
            r_quot     <= 32'd0;
            r_rem      <= 32'd0;
            r_rs1      <= 32'd0;
            r_count    <= 5'd0;
            r_signed   <= 1'b0;
            r_rem_sel  <= 1'b0;
            r_q_sign   <= 1'b0;
            r_r_sign   <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_start) begin
            r_dividend <= w_mag1;
            r_divisor  <= w_mag2;
            r_quot     <= 32'd0;
            r_rem      <= 32'd0;
            r_rs1      <= d_rs1_i;
            r_count    <= 5'd0;
            r_signed   <= w_signed;
            r_rem_sel  <= d_fun_i[1];
            r_q_sign   <= d_rs1_i[31] ^ d_rs2_i[31];
            r_r_sign   <= d_rs1_i[31];
            r_div0     <= w_div0;
            r_ovf      <= w_ovf;
        end else if ((r_state == ST_CALC) && !kill_i) begin
            r_rem      <= w_ge ? w_diff[31:0] : w_trial[31:0];
            r_quot     <= {r_quot[30:0], w_ge};
            r_dividend <= {r_dividend[30:0], 1'b0};
            r_count    <= r_count + 5'd1;
        end
    end

    // Writeback register updates only on a completed (unkilled) FIX cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd <= 32'd0;
        end else if ((r_state == ST_FIX) && !kill_i) begin
            r_rd <= w_result;
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign w_rd_o = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_urv_divide.sv
`default_nettype none
// ============================================================================
//  Module      : tb_urv_divide
//  Description : Self-checking bench for urv_divide; two instances cover
//                EARLY_OUT=1 (dut_a) and EARLY_OUT=0 (dut_b).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_urv_divide;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a;
    logic        start_b;
    logic        kill;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  fun;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] rd_a, rd_b;

    always #5 clk = ~clk;

    urv_divide #(.EARLY_OUT(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .kill_i(kill),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .d_fun_i(fun),
        .busy_o(busy_a), .done_o(done_a), .w_rd_o(rd_a)
    );

    urv_divide #(.EARLY_OUT(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .kill_i(kill),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .d_fun_i(fun),
        .busy_o(busy_b), .done_o(done_b), .w_rd_o(rd_b)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_a = 32'd0;
    logic [31:0] last_b = 32'd0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] e;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics straight from the ISA rules
    function automatic logic [31:0] ref_val(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        int sa;
        int sb;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
            sa = int'(a);
            sb = int'(b);
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input bit early);
        bit special;
        special = (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (early && special) ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op (caller sits just after a rising edge), wait for done.
    // Returns in the done cycle so a following call starts back-to-back.
    task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] exp, input bit mid);
        int n;
        int lat;
        bit busy_bad;
        lat = ref_lat(a, b, f, !sel);
        rs1 = a; rs2 = b; fun = f;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        n = 0;
        busy_bad = 1'b0;
        while (n < 40) begin
            if (sel ? done_b : done_a) break;
            if (!(sel ? busy_b : busy_a)) busy_bad = 1'b1;
            if (mid && n == 5) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
                rs1 = $urandom;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_a = 1'b0; start_b = 1'b0;
        if (sel ? busy_b : busy_a) busy_bad = 1'b1;
        check($sformatf("lat%0d f=%0d a=%h b=%h", sel, f, a, b), 32'(n), 32'(lat));
        check($sformatf("val%0d f=%0d a=%h b=%h", sel, f, a, b), sel ? rd_b : rd_a, exp);
        check($sformatf("busy%0d f=%0d a=%h b=%h", sel, f, a, b), {31'd0, busy_bad}, 32'd0);
        if (sel) last_b = exp; else last_a = exp;
    endtask

    vec_t dir [14] = '{
        '{32'd100,         32'd7,           3'b101, 32'd14},
        '{32'd100,         32'd7,           3'b111, 32'd2},
        '{32'hFFFF_FFF9,   32'd2,           3'b100, 32'hFFFF_FFFD},
        '{32'hFFFF_FFF9,   32'd2,           3'b110, 32'hFFFF_FFFF},
        '{32'd7,           32'hFFFF_FFFE,   3'b100, 32'hFFFF_FFFD},
        '{32'd7,           32'hFFFF_FFFE,   3'b110, 32'd1},
        '{32'h1234_5678,   32'd0,           3'b100, 32'hFFFF_FFFF},
        '{32'h1234_5678,   32'd0,           3'b101, 32'hFFFF_FFFF},
        '{32'h1234_5678,   32'd0,           3'b110, 32'h1234_5678},
        '{32'h1234_5678,   32'd0,           3'b111, 32'h1234_5678},
        '{32'h8000_0000,   32'hFFFF_FFFF,   3'b100, 32'h8000_0000},
        '{32'h8000_0000,   32'hFFFF_FFFF,   3'b110, 32'd0},
        '{32'h8000_0000,   32'hFFFF_FFFF,   3'b101, 32'd0},
        '{32'h8000_0000,   32'hFFFF_FFFF,   3'b111, 32'h8000_0000}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [31:0] a, b;
        logic [2:0]  f;
        rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; kill = 1'b0;
        rs1 = 32'd0; rs2 = 32'd0; fun = 3'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_rd",   rd_a, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on both variants
        for (int i = 0; i < 14; i++) do_op(1'b0, dir[i].a, dir[i].b, dir[i].f, dir[i].e, 1'b0);
        for (int i = 0; i < 14; i++) do_op(1'b1, dir[i].a, dir[i].b, dir[i].f, dir[i].e, 1'b0);

        // Kill during CALC
        @(posedge clk); #1;
        rs1 = 32'd1000; rs2 = 32'd3; fun = 3'b101; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("kill_pre_busy", {31'd0, busy_a}, 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", {31'd0, busy_a}, 32'd0);
        check("kill_done", {31'd0, done_a}, 32'd0);
        check("kill_rd",   rd_a, last_a);
        seen = 1'b0;
        repeat (3) begin
            if (done_a) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("kill_nodone", {31'd0, seen}, 32'd0);

        // Kill in IDLE blocks the start
        start_a = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; kill = 1'b0;
        check("kill_idle_busy", {31'd0, busy_a}, 32'd0);

        // Kill in FIX (early-out path reaches FIX after one edge)
        rs1 = 32'hCAFE_0001; rs2 = 32'd0; fun = 3'b100; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("fix_busy", {31'd0, busy_a}, 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("killfix_done", {31'd0, done_a}, 32'd0);
        check("killfix_busy", {31'd0, busy_a}, 32'd0);
        check("killfix_rd",   rd_a, last_a);

        // Fresh op with a stray start pulse mid-operation
        do_op(1'b0, 32'd50, 32'd5, 3'b101, 32'd10, 1'b1);

        // Asynchronous reset mid-CALC
        @(posedge clk); #1;
        rs1 = 32'd1000; rs2 = 32'd3; fun = 3'b101; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_a}, 32'd0);
        check("arst_done", {31'd0, done_a}, 32'd0);
        check("arst_rd",   rd_a, 32'd0);
        #1 rst_n = 1'b1;
        last_a = 32'd0; last_b = 32'd0;
        @(posedge clk); #1;
        check("arst_idle", {31'd0, busy_a}, 32'd0);

        // Randomized back-to-back traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            a = pick(); b = pick(); f = 3'($urandom_range(0, 7));
            do_op(1'b0, a, b, f, ref_val(a, b, f), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            a = pick(); b = pick(); f = 3'($urandom_range(0, 7));
            do_op(1'b1, a, b, f, ref_val(a, b, f), 1'b0);
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/urv_divide.md
Name: urv_divide

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions; counterpart to the single-cycle-issue multiplier in the execute stage.
- Accepts operands on a start strobe and computes one quotient bit per clock.
- Applies sign fix-up and the RISC-V special cases (divide-by-zero, signed overflow).
- Returns a 32-bit writeback value with a one-cycle done pulse; the pipeline holds the instruction while busy_o is high.

Parameters:
- EARLY_OUT, 1: 1 = divide-by-zero and signed-overflow results complete in 1 cycle; 0 = special cases take full iterative latency (result still spec-correct).

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  start strobe; sampled only in IDLE.
- kill_i  in  1  pipeline flush; aborts the operation in progress.
- d_rs1_i  in  32  dividend.
- d_rs2_i  in  32  divisor.
- d_fun_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are treated by bit0 = unsigned and bit1 = remainder.
- busy_o  out  1  operation in progress (any state other than IDLE).
- done_o  out  1  single-cycle pulse; w_rd_o is valid in that cycle.
- w_rd_o  out  32  quotient or remainder; holds its value until the next done.

Behaviour:
- Reset: asynchronous while rst_n_i=0. State=IDLE, busy_o=0, done_o=0, w_rd_o=0, all internal registers cleared. Reset mid-operation abandons the operation immediately with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start_i=1 and kill_i=0 at edge E0, latch operands and function.
  - Compute magnitudes |rs1| and |rs2| when signed, else use raw values.
  - Record quotient sign = s1^s2 and remainder sign = s1.
  - Clear count, remainder accumulator and quotient.
  - Next state is CALC, or FIX if EARLY_OUT=1 and the operation is a special case.
- CALC:
  - Each edge: remainder = {rem[30:0], dividend msb}; shift dividend left.
  - If remainder >= divisor (33-bit compare), subtract and set quotient bit 1, else set 0.
  - count increments 0..31; at the edge with count==31, go to FIX.
  - Edges E1..E32 perform the 32 iterations.
- FIX (one edge):
  - Select quotient or remainder.
  - Negate the quotient if signed and the quotient sign is set; negate the remainder if signed and the remainder sign is set.
  - Apply special-case overrides.
  - Register w_rd_o, pulse done_o=1 for exactly one cycle, return to IDLE.
- Latency: done_o is high in the cycle after edge E33 (normal path) or after E1 (early-out).
- start_i is ignored while busy_o=1. start_i may be asserted in the same cycle as done_o: that cycle is IDLE, so the start is accepted.
- Special cases (override the iterative result in all modes):
  - divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM for the same operands -> 0.
- Arithmetic: the 33-bit internal subtractor avoids compare overflow; magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- kill_i:
  - Any state other than IDLE -> IDLE at the next edge, busy_o=0, no done pulse, w_rd_o unchanged.
  - kill_i in IDLE blocks acceptance of start_i.
  - kill_i in FIX suppresses done_o and the w_rd_o update.
- done_o and busy_o are registered outputs (no combinational path from inputs).

Test Plan:
- DIVU 100/7, start at E0 -> busy_o=1 over E0..E33, done_o=1 after E33, w_rd_o=14; REMU with same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD; REM -> 1.
- Divisor 0 with dividend 0x12345678, EARLY_OUT=1 -> DIV/DIVU give 0xFFFFFFFF, REM/REMU give 0x12345678, done after E1; repeat with EARLY_OUT=0 -> same values, done after E33.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU for the same operands -> 0; REMU -> 0x80000000.
- kill_i asserted 10 cycles after start -> busy_o=0 next cycle, no done pulse, w_rd_o unchanged; immediate new DIVU 50/5 -> 10, done 33 cycles later; start_i pulsed mid-operation is ignored.
- rst_n_i low mid-CALC -> busy_o, done_o and w_rd_o are 0 asynchronously before the next edge; after release, back-to-back ops (start in the done cycle) each return correct results.
